systolic_result_reader: RTL

Drain side of the 2x2 systolic array. On a start pulse it snapshots the four accumulator outputs (c00, c01, c10, c11). It then serialises them as OUT_WIDTH-bit beats over a valid/ready stream toward the chip output pins. It decouples array compute timing from a slow or back-pressured consumer, so the array may begin the next tile as soon as the snapshot is taken.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/result_beat_mux.sv | 25 ++
 rtl/systolic_result_reader.sv | 116 +++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic array blocks: default widths, PE count,
// reader FSM state encoding and beat-count helper.
package tpu_pkg;

    localparam int unsigned DEFAULT_ACC_WIDTH = 16;
    localparam int unsigned DEFAULT_OUT_WIDTH = 8;
    localparam int unsigned NUM_PE            = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StFin
    } state_e;

    function automatic int unsigned beats_per_elem(input int unsigned acc_w,
                                                   input int unsigned out_w);
        return acc_w / out_w;
    endfunction

endpackage

// File: rtl/result_beat_mux.sv
// Selects one OUT_WIDTH beat from a packed snapshot by beat index; beat 0 is the
// least-significant slice of the first element.
module result_beat_mux #(
    parameter int unsigned ACC_WIDTH = 16,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned NUM_ELEM  = 4,
    parameter int unsigned IDX_W     = 4
) (
    input  logic [NUM_ELEM*ACC_WIDTH-1:0] snap,
    input  logic [IDX_W-1:0]              idx,
    output logic [OUT_WIDTH-1:0]          beat
);

    localparam int unsigned NUM_BEATS = NUM_ELEM * (ACC_WIDTH / OUT_WIDTH);

    always_comb begin
        beat = '0;
        for (int i = 0; i < NUM_BEATS; i++) begin
            if (idx == IDX_W'(i)) begin
                beat = snap[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_result_reader.sv
// Snapshots the 2x2 array results on start and streams them out as valid/ready beats.
// Optional macro RESULT_CHECKSUM_EN appends an XOR checksum beat to each frame.
module systolic_result_reader
    import tpu_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = DEFAULT_ACC_WIDTH,
    parameter int unsigned OUT_WIDTH = DEFAULT_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ACC_WIDTH-1:0] c00,
    input  logic [ACC_WIDTH-1:0] c01,
    input  logic [ACC_WIDTH-1:0] c10,
    input  logic [ACC_WIDTH-1:0] c11,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned BEATS_PER_ELEM = beats_per_elem(ACC_WIDTH, OUT_WIDTH);
    localparam int unsigned NUM_BEATS      = NUM_PE * BEATS_PER_ELEM;
`ifdef RESULT_CHECKSUM_EN
    localparam int unsigned FRAME_BEATS    = NUM_BEATS + 1;
`else
    localparam int unsigned FRAME_BEATS    = NUM_BEATS;
`endif
    localparam int unsigned CNT_W          = $clog2(FRAME_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_BEATS - 1);

    state_e                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [NUM_PE*ACC_WIDTH-1:0] snap_q;
    logic                        valid_q, last_q, busy_q, done_q;
    logic [OUT_WIDTH-1:0]        slice_beat, beat;

    result_beat_mux #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .NUM_ELEM  (NUM_PE),
        .IDX_W     (CNT_W)
    ) u_beat_mux (
        .snap (snap_q),
        .idx  (cnt_q),
        .beat (slice_beat)
    );

`ifdef RESULT_CHECKSUM_EN
    logic [OUT_WIDTH-1:0] csum;

    always_comb begin
        csum = '0;
        for (int i = 0; i < NUM_BEATS; i++) begin
            csum = csum ^ snap_q[i*OUT_WIDTH +: OUT_WIDTH];
        end
        beat = (cnt_q == LAST_IDX) ? csum : slice_beat;
    end
`else
    assign beat = slice_beat;
`endif

    // Gate with valid so the bus reads zero between frames.
    assign out_data  = valid_q ? beat : '0;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                // FIN accepts start just like IDLE, giving back-to-back frames.
                StIdle, StFin: begin
                    done_q <= 1'b0;
                    if (start) begin
                        snap_q  <= {c11, c10, c01, c00};
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        last_q  <= 1'(FRAME_BEATS == 1);
                        state_q <= StSend;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StSend: begin
                    if (out_ready) begin
                        if (cnt_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end else begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            last_q <= ((cnt_q + CNT_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
